// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter for four requesters (A..D) that also drives the
//   select lines of a downstream 4:1 mux. A grant is held while its
//   requester keeps asking, but it is handed over after MAX_HOLD cycles
//   if somebody else is waiting. Hand-over happens without an idle cycle.
//
// Parameters
//   MAX_HOLD : cycles a grant may be held while another requester waits (1-15)
// Ports
//   CLK   in   system clock, rising edge
//   RST   in   asynchronous active-high reset
//   REQ   in   [3:0] requests, bit0=A, bit1=B, bit2=C, bit3=D
//   GNT   out  [3:0] registered one-hot grant (zero when idle)
//   VALID out  registered, high while a grant is active
//   S1    out  registered mux select high bit (A=11, B=10, C=01, D=00)
//   S0    out  registered mux select low bit
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       VALID,
  output logic       S1,
  output logic       S0
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_r, state_s;
  logic [1:0] ptr_r, ptr_s;    // round-robin start index
  logic [1:0] idx_r, idx_s;    // index currently granted
  logic [3:0] cnt_r, cnt_s;    // cycles the current grant has been held
  logic [3:0] gnt_r, gnt_s;
  logic       valid_r, valid_s;
  logic [1:0] sel_r, sel_s;    // {S1,S0}

  logic [2:0] win_s;           // {found, index} searching REQ from ptr_r
  logic [2:0] next_win_s;      // {found, index} searching others from idx_r+1
  logic [3:0] others_s;        // pending requests other than the granted one
  logic [1:0] ptr_inc_s;
  logic       release_s;

  // First set bit of req, scanning start, start+1, ... modulo 4.
  // Returns {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!res[2] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Select lines are the bitwise complement of the index (A=0 -> 11 ... D=3 -> 00).
  function automatic logic [1:0] sel_of(input logic [1:0] idx);
    return ~idx;
  endfunction

  // Next-state and next-output computation.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    gnt_s      = gnt_r;
    sel_s      = sel_r;
    ptr_inc_s  = idx_r + 2'd1;
    others_s   = REQ & ~(4'b0001 << idx_r);
    win_s      = pick(REQ, ptr_r);
    // The released index sits last in the order from idx_r+1 and is masked
    // out anyway, so it can never win its own hand-over.
    next_win_s = pick(others_s, ptr_inc_s);
    release_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (win_s[2]) begin
          state_s = BUSY;
          idx_s   = win_s[1:0];
          cnt_s   = 4'd0;
          gnt_s   = 4'b0001 << win_s[1:0];
          sel_s   = sel_of(win_s[1:0]);
        end else begin
          gnt_s   = 4'b0000;
          cnt_s   = 4'd0;
        end
      end
      BUSY: begin
        release_s = !REQ[idx_r] || ((cnt_r == HOLD_LAST) && (others_s != 4'b0000));
        if (release_s) begin
          ptr_s = ptr_inc_s;
          cnt_s = 4'd0;
          if (next_win_s[2]) begin
            idx_s = next_win_s[1:0];
            gnt_s = 4'b0001 << next_win_s[1:0];
            sel_s = sel_of(next_win_s[1:0]);
          end else begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
          end
        end else if (cnt_r != HOLD_LAST) begin
          cnt_s = cnt_r + 4'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        cnt_s   = 4'd0;
      end
    endcase

    valid_s = (gnt_s != 4'b0000);
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      idx_r   <= 2'd0;
      cnt_r   <= 4'd0;
      gnt_r   <= 4'b0000;
      valid_r <= 1'b0;
      sel_r   <= 2'b00;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      gnt_r   <= gnt_s;
      valid_r <= valid_s;
      sel_r   <= sel_s;
    end
  end

  assign GNT   = gnt_r;
  assign VALID = valid_r;
  assign S1    = sel_r[1];
  assign S0    = sel_r[0];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int MH = 4;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       VALID;
  logic       S1;
  logic       S0;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .GNT  (GNT),
    .VALID(VALID),
    .S1   (S1),
    .S0   (S0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[17];

  // Behavioural model: owner index (-1 = none), pointer, held cycles, select.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  // Apply the arbitration rules for one clock edge with request vector r.
  task automatic model_step(input logic [3:0] r);
    int  others;
    int  old;
    bit  found;
    int  i;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (!found && r[i]) begin
          found   = 1;
          m_owner = i;
          m_cnt   = 0;
          m_sel   = 3 - i;
        end
      end
    end else begin
      others = 0;
      for (int k = 0; k < 4; k++) if (k != m_owner && r[k]) others++;
      if (!r[m_owner] || (m_cnt == MH - 1 && others > 0)) begin
        old     = m_owner;
        m_ptr   = (old + 1) % 4;
        m_owner = -1;
        m_cnt   = 0;
        found   = 0;
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr + k) % 4;
          if (!found && i != old && r[i]) begin
            found   = 1;
            m_owner = i;
            m_sel   = 3 - i;
          end
        end
      end else if (m_cnt < MH - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk({tag, "_gnt"}, GNT, eg);
    chk({tag, "_valid"}, {3'b000, VALID}, {3'b000, (m_owner >= 0)});
    chk({tag, "_sel"}, {2'b00, S1, S0}, 4'(m_sel));
    chk({tag, "_onehot"}, {3'b000, ($countones(GNT) <= 1)}, 4'b0001);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = 4'b0000;
    #2;
    chk("rst_gnt", GNT, 4'b0000);
    chk("rst_valid", {3'b000, VALID}, 4'b0000);
    chk("rst_sel", {2'b00, S1, S0}, 4'b0000);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] r;
    int         idx;

    RST = 1'b1;
    REQ = 4'b0000;

    tbl[0]  = '{4'b0001, 4'b0001, 1'b1, 2'b11};
    tbl[1]  = '{4'b0001, 4'b0001, 1'b1, 2'b11};
    tbl[2]  = '{4'b0001, 4'b0001, 1'b1, 2'b11};
    tbl[3]  = '{4'b0001, 4'b0001, 1'b1, 2'b11};
    tbl[4]  = '{4'b0001, 4'b0001, 1'b1, 2'b11};
    tbl[5]  = '{4'b0001, 4'b0001, 1'b1, 2'b11};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 2'b11};
    tbl[7]  = '{4'b0010, 4'b0010, 1'b1, 2'b10};
    tbl[8]  = '{4'b0101, 4'b0100, 1'b1, 2'b01};
    tbl[9]  = '{4'b1000, 4'b1000, 1'b1, 2'b00};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 2'b00};
    tbl[11] = '{4'b0011, 4'b0001, 1'b1, 2'b11};
    tbl[12] = '{4'b0011, 4'b0001, 1'b1, 2'b11};
    tbl[13] = '{4'b0011, 4'b0001, 1'b1, 2'b11};
    tbl[14] = '{4'b0011, 4'b0001, 1'b1, 2'b11};
    tbl[15] = '{4'b0011, 4'b0010, 1'b1, 2'b10};
    tbl[16] = '{4'b0011, 4'b0010, 1'b1, 2'b10};

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      REQ = tbl[i].req;
      @(negedge CLK);
      chk($sformatf("tbl%0d_gnt", i), GNT, tbl[i].gnt);
      chk($sformatf("tbl%0d_valid", i), {3'b000, VALID}, {3'b000, tbl[i].valid});
      chk($sformatf("tbl%0d_sel", i), {2'b00, S1, S0}, {2'b00, tbl[i].sel});
    end

    // All four requesting: A,B,C,D,A each for exactly MH cycles, no gaps.
    do_reset();
    REQ = 4'b1111;
    for (int c = 0; c < 5 * MH; c++) begin
      @(negedge CLK);
      idx = (c / MH) % 4;
      chk($sformatf("rot%0d_gnt", c), GNT, 4'(1 << idx));
      chk($sformatf("rot%0d_sel", c), {2'b00, S1, S0}, 4'(3 - idx));
      chk($sformatf("rot%0d_valid", c), {3'b000, VALID}, 4'b0001);
    end

    // Asynchronous reset between edges during a grant on C.
    do_reset();
    REQ = 4'b0100;
    @(negedge CLK);
    chk("arst_pre_gnt", GNT, 4'b0100);
    chk("arst_pre_sel", {2'b00, S1, S0}, 4'b0001);
    #2 RST = 1'b1;
    #1;
    chk("arst_now_gnt", GNT, 4'b0000);
    chk("arst_now_valid", {3'b000, VALID}, 4'b0000);
    chk("arst_now_sel", {2'b00, S1, S0}, 4'b0000);
    @(negedge CLK);
    chk("arst_hold_gnt", GNT, 4'b0000);
    RST = 1'b0;
    REQ = 4'b0010;
    @(negedge CLK);
    chk("arst_post_gnt", GNT, 4'b0010);
    chk("arst_post_valid", {3'b000, VALID}, 4'b0001);
    chk("arst_post_sel", {2'b00, S1, S0}, 4'b0010);

    // Randomized traffic against the model.
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      REQ = r;
      model_step(r);
      @(negedge CLK);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, the maximum number of consecutive cycles a grant is held while another requester waits (legal range 1-15).
REQ-002 CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset; asynchronous and active-high.
REQ-004 REQ  input  4  request vector; REQ[0]=source A, REQ[1]=B, REQ[2]=C, REQ[3]=D.
REQ-005 GNT  output 4  registered one-hot grant vector, same bit mapping as REQ; all-zero when nothing is granted.
REQ-006 VALID  output 1  registered; high when exactly one GNT bit is high.
REQ-007 S1  output 1  registered mux select, high bit; drives the 4:1 mux S1 input.
REQ-008 S0  output 1  registered mux select, low bit; drives the 4:1 mux S0 input.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and BUSY (one grant active).
REQ-010 Select encoding SHALL be: A -> S1S0=11, B -> 10, C -> 01, D -> 00.
REQ-011 S1/S0 SHALL change only on the edge at which GNT changes to a new non-zero value, and SHALL hold their last value in IDLE.
REQ-012 A 2-bit priority pointer PTR SHALL select the highest-priority index; search order is PTR, PTR+1, PTR+2, PTR+3, modulo 4.
REQ-013 IDLE: if REQ != 0 at an edge, the winning index per REQ-012 SHALL be granted at that edge (GNT/VALID/S1S0 valid the following cycle, latency 1 cycle); state -> BUSY; hold counter CNT := 0.
REQ-014 IDLE with REQ = 0 SHALL remain IDLE with GNT=0, VALID=0.
REQ-015 BUSY: CNT SHALL increment by 1 each cycle, saturating at MAX_HOLD-1.
REQ-016 BUSY release SHALL occur when the granted REQ bit is 0, or when CNT = MAX_HOLD-1 and at least one other REQ bit is 1.
REQ-017 On release PTR SHALL become (granted index + 1) mod 4.
REQ-018 On release with any other REQ bit set, the next winner (per REQ-012 using the updated PTR, excluding the released index) SHALL be granted at the same edge: no idle bubble, CNT := 0, state stays BUSY.
REQ-019 On release with no other REQ bit set, state SHALL go to IDLE, GNT=0, VALID=0.
REQ-020 The granted requester at CNT = MAX_HOLD-1 with no other request pending SHALL keep the grant indefinitely (no forced release).
REQ-021 GNT SHALL never have more than one bit set; VALID SHALL equal OR-reduction of GNT.
REQ-022 A requester dropping REQ and re-raising it in the same cycle as another's release SHALL be arbitrated as any other pending request.

Reset
REQ-023 Asserting RST SHALL immediately (without CLK) force: state IDLE, GNT=0000, VALID=0, S1=0, S0=0, PTR=0, CNT=0.
REQ-024 Reset asserted mid-grant SHALL abort the grant with no further output change until after RST deasserts.
REQ-025 The first rising CLK edge with RST low SHALL perform normal IDLE arbitration.

Verification
REQ-026 Reset, then REQ=0001 held -> one cycle later GNT=0001, VALID=1, S1S0=11; held indefinitely while REQ stays 0001.
REQ-027 After reset REQ=1111 held, MAX_HOLD=4 -> grants A,B,C,D,A each for exactly 4 cycles, S1S0 sequence 11,10,01,00,11, no gap cycles.
REQ-028 Grant on B (PTR=1), drop REQ[1] while REQ=0101 -> next edge GNT=0100 (C), PTR=2, S1S0=01.
REQ-029 Grant on D, REQ goes to 0000 -> next edge GNT=0000, VALID=0, S1S0 stays 00, PTR=0.
REQ-030 RST pulsed asynchronously between edges during grant on C -> GNT=0000, VALID=0, S1S0=00 immediately; after release REQ=0010 -> GNT=0010 one cycle later.
